// File: rtl/dac_delay_align_pkg.sv
// -----------------------------------------------------------------------------
// dac_delay_align_pkg
//
// Constants and helpers shared by the transmit chain for per-channel delay
// alignment ahead of the RFDAC.
//
// Contents
//   DEF_*          default geometry of the transmit datapath
//   delay_bits()   width of one delay field for a given delay line depth
//   cfg_width()    total width of the packed delay configuration word
//                  (one field per channel plus one trigger field)
//   cfg_field_lsb() bit position of field i inside the configuration word
// -----------------------------------------------------------------------------
package dac_delay_align_pkg;

  localparam int DEF_CHANNELS         = 8;
  localparam int DEF_PARALLEL_SAMPLES = 16;
  localparam int DEF_SAMPLE_WIDTH     = 16;
  // Delay line depth in words; must be a power of two so that the read
  // address wraps naturally in DELAY_BITS-wide arithmetic.
  localparam int DEF_MAX_DELAY        = 16;

  function automatic int delay_bits(input int max_delay);
    return $clog2(max_delay);
  endfunction

  function automatic int cfg_width(input int channels, input int max_delay);
    return delay_bits(max_delay) * (channels + 1);
  endfunction

  function automatic int cfg_field_lsb(input int field, input int max_delay);
    return field * delay_bits(max_delay);
  endfunction

endpackage

// File: rtl/dac_delay_align_delay_line.sv
// -----------------------------------------------------------------------------
// dac_delay_align_delay_line
//
// Circular buffer of DEPTH entries, each a DATA_W data word plus a valid bit.
// The write pointer is owned by the parent so that every instance shares the
// same time base. The read side is combinational; the parent registers it.
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset, clears the stored valid bits
//   wr_ptr_i   shared write pointer (entry written at this edge)
//   delay_i    delay in words, 0 .. DEPTH-1
//   wr_data_i  data word written at wr_ptr_i
//   wr_vld_i   valid bit written at wr_ptr_i
//   rd_data_o  data word that entered delay_i edges ago (current input if 0)
//   rd_vld_o   valid bit matching rd_data_o
// -----------------------------------------------------------------------------
module dac_delay_align_delay_line
  import dac_delay_align_pkg::*;
#(
  parameter  int DATA_W = DEF_PARALLEL_SAMPLES * DEF_SAMPLE_WIDTH,
  parameter  int DEPTH  = DEF_MAX_DELAY,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [PTR_W-1:0]  delay_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_vld_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_vld_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  rd_addr;

  // Wraps mod DEPTH. For delay DEPTH-1 this lands on wr_ptr_i+1, the oldest
  // entry, which is read here before it is overwritten one edge later.
  assign rd_addr = wr_ptr_i - delay_i;

  // Data words carry no reset; only the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    mem_q[wr_ptr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[wr_ptr_i] <= wr_vld_i;
    end
  end

  // Delay 0 means "the word being written now": the memory slot at wr_ptr_i
  // still holds the word from DEPTH edges ago, so bypass it.
  always_comb begin
    rd_data_o = mem_q[rd_addr];
    rd_vld_o  = vld_q[rd_addr];
    if (delay_i == '0) begin
      rd_data_o = wr_data_i;
      rd_vld_o  = wr_vld_i;
    end
  end

endmodule

// File: rtl/dac_delay_align.sv
// -----------------------------------------------------------------------------
// dac_delay_align
//
// Per-channel programmable delay in front of the RFDAC, so that channels with
// different analogue path lengths line up, plus a matching delay for the
// trigger. Each channel output at cycle t equals its input at t-d_i-1.
//
// Build option
//   DAC_DELAY_ALIGN_TRIGGER_DELAY_EN  when defined, the trigger goes through
//     its own 1-bit delay line using the last configuration field; otherwise
//     the trigger is registered once and that field is ignored.
//
// Ports
//   clk              DAC clock
//   reset_n          asynchronous active-low reset
//   data_in_data     CHANNELS words of PARALLEL_SAMPLES*SAMPLE_WIDTH bits
//   data_in_valid    one valid bit per channel
//   data_out_data    delayed words to the RFDAC (registered)
//   data_out_valid   delayed valid bits (registered)
//   config_in_data   packed delays: field i = [i*DELAY_BITS +: DELAY_BITS],
//                    field CHANNELS = trigger delay
//   config_in_valid  configuration handshake valid
//   config_in_ready  always 1 out of reset
//   trigger_in       trigger from the trigger manager
//   trigger_out      trigger aligned with the delayed data (registered)
// -----------------------------------------------------------------------------
module dac_delay_align
  import dac_delay_align_pkg::*;
#(
  parameter int CHANNELS         = DEF_CHANNELS,
  parameter int PARALLEL_SAMPLES = DEF_PARALLEL_SAMPLES,
  parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
  parameter int MAX_DELAY        = DEF_MAX_DELAY
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic [CHANNELS-1:0][PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_in_data,
  input  logic [CHANNELS-1:0]                                   data_in_valid,
  output logic [CHANNELS-1:0][PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out_data,
  output logic [CHANNELS-1:0]                                   data_out_valid,
  input  logic [$clog2(MAX_DELAY)*(CHANNELS+1)-1:0]             config_in_data,
  input  logic                                                  config_in_valid,
  output logic                                                  config_in_ready,
  input  logic                                                  trigger_in,
  output logic                                                  trigger_out
);

  localparam int DELAY_BITS = delay_bits(MAX_DELAY);
  localparam int WORD_W     = PARALLEL_SAMPLES * SAMPLE_WIDTH;

  // Control state
  logic [DELAY_BITS-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CHANNELS:0][DELAY_BITS-1:0]   delay_q, delay_d;
  logic                                ready_q;

  // Delay line read side
  logic [CHANNELS-1:0][WORD_W-1:0]     rd_data;
  logic [CHANNELS-1:0]                 rd_vld;
  logic                                trig_d;

  // Output registers
  logic [CHANNELS-1:0][WORD_W-1:0]     dout_data_q;
  logic [CHANNELS-1:0]                 dout_vld_q;
  logic                                trig_q;

  // Write pointer advances every cycle regardless of input valid, so a
  // channel's delay counts clock cycles, not valid words.
  always_comb begin
    wr_ptr_d = wr_ptr_q + 1'b1;
    delay_d  = delay_q;
    if (config_in_valid && ready_q) begin
      delay_d = config_in_data;
    end
  end

  // A new configuration takes effect on the very next read; the buffers are
  // left alone, so the output jumps to the new offset in the history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      delay_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      delay_q  <= delay_d;
      ready_q  <= 1'b1;
    end
  end

  assign config_in_ready = ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dac_delay_align_delay_line #(
      .DATA_W (WORD_W),
      .DEPTH  (MAX_DELAY)
    ) u_line (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_ptr_i  (wr_ptr_q),
      .delay_i   (delay_q[i]),
      .wr_data_i (data_in_data[i]),
      .wr_vld_i  (data_in_valid[i]),
      .rd_data_o (rd_data[i]),
      .rd_vld_o  (rd_vld[i])
    );
  end

`ifdef DAC_DELAY_ALIGN_TRIGGER_DELAY_EN
  logic trig_rd_data;
  logic trig_rd_vld;

  // The trigger rides in the valid bit so reset clears pending pulses; the
  // data bit carries the same value and is only ANDed in for symmetry.
  dac_delay_align_delay_line #(
    .DATA_W (1),
    .DEPTH  (MAX_DELAY)
  ) u_trig_line (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_ptr_i  (wr_ptr_q),
    .delay_i   (delay_q[CHANNELS]),
    .wr_data_i (trigger_in),
    .wr_vld_i  (trigger_in),
    .rd_data_o (trig_rd_data),
    .rd_vld_o  (trig_rd_vld)
  );

  assign trig_d = trig_rd_vld & trig_rd_data;
`else
  // Trigger field is latched with the others but has no consumer here.
  logic unused_trig_delay;
  assign unused_trig_delay = ^delay_q[CHANNELS];
  assign trig_d            = trigger_in;
`endif

  // Output register stage: gives the one cycle of latency seen at delay 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_data_q <= '0;
      dout_vld_q  <= '0;
      trig_q      <= 1'b0;
    end else begin
      dout_data_q <= rd_data;
      dout_vld_q  <= rd_vld;
      trig_q      <= trig_d;
    end
  end

  assign data_out_data  = dout_data_q;
  assign data_out_valid = dout_vld_q;
  assign trigger_out    = trig_q;

endmodule

// File: tb/tb_dac_delay_align.sv
module tb_dac_delay_align;

  localparam int CH     = 8;
  localparam int PS     = 16;
  localparam int SW     = 16;
  localparam int MD     = 16;
  localparam int DB     = 4;
  localparam int WORD_W = PS * SW;
  localparam int CFG_W  = DB * (CH + 1);
`ifdef DAC_DELAY_ALIGN_TRIGGER_DELAY_EN
  localparam int TL = 9;
`else
  localparam int TL = 0;
`endif

  logic                          clk;
  logic                          reset_n;
  logic [CH-1:0][WORD_W-1:0]     data_in_data;
  logic [CH-1:0]                 data_in_valid;
  logic [CH-1:0][WORD_W-1:0]     data_out_data;
  logic [CH-1:0]                 data_out_valid;
  logic [CFG_W-1:0]              config_in_data;
  logic                          config_in_valid;
  logic                          config_in_ready;
  logic                          trigger_in;
  logic                          trigger_out;

  int checks = 0;
  int errors = 0;

  dac_delay_align #(
    .CHANNELS         (CH),
    .PARALLEL_SAMPLES (PS),
    .SAMPLE_WIDTH     (SW),
    .MAX_DELAY        (MD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data_in_data    (data_in_data),
    .data_in_valid   (data_in_valid),
    .data_out_data   (data_out_data),
    .data_out_valid  (data_out_valid),
    .config_in_data  (config_in_data),
    .config_in_valid (config_in_valid),
    .config_in_ready (config_in_ready),
    .trigger_in      (trigger_in),
    .trigger_out     (trigger_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int scen;
    int cyc;
    int ch;      // -1 selects trigger_out
    bit ev;      // expected valid / trigger
    int en;      // ramp index expected on the data when valid
  } chk_t;

  typedef struct {
    logic [CFG_W-1:0] cfg;
    int               chg_edge;
    logic [CFG_W-1:0] cfg2;
    logic [31:0]      ch2_vld;
    int               trig_edge;
  } scen_t;

  chk_t  tbl[$];
  scen_t sc[4];

  function automatic logic [WORD_W-1:0] word(input int ch, input int n);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int j = 0; j < PS; j++) w[j*SW +: SW] = {ch[3:0], n[7:0], j[3:0]};
    return w;
  endfunction

  function automatic logic [CFG_W-1:0] mkcfg(input int d0, input int d1, input int d2,
                                             input int d3, input int dt);
    logic [CFG_W-1:0] c;
    c = '0;
    c[0*DB +: DB]  = d0[DB-1:0];
    c[1*DB +: DB]  = d1[DB-1:0];
    c[2*DB +: DB]  = d2[DB-1:0];
    c[3*DB +: DB]  = d3[DB-1:0];
    c[CH*DB +: DB] = dt[DB-1:0];
    return c;
  endfunction

  task automatic check(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive_ramp(input int n, input logic [CH-1:0] vld);
    for (int i = 0; i < CH; i++) data_in_data[i] = word(i, n);
    data_in_valid = vld;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    data_in_valid = '0;
    config_in_valid = 1'b0;
    trigger_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check({tag, "_rst_vld"},   WORD_W'(data_out_valid), '0);
    check({tag, "_rst_data"},  WORD_W'(data_out_data[0]), '0);
    check({tag, "_rst_trig"},  WORD_W'(trigger_out), '0);
    check({tag, "_rst_ready"}, WORD_W'(config_in_ready), '0);
    reset_n = 1'b1;
  endtask

  task automatic configure(input logic [CFG_W-1:0] cfg);
    int n;
    n = 0;
    data_in_valid   = '0;
    config_in_data  = cfg;
    config_in_valid = 1'b1;
    while (!config_in_ready && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check("cfg_ready", WORD_W'(config_in_ready), WORD_W'(1'b1));
    @(posedge clk); #1;
    config_in_valid = 1'b0;
  endtask

  logic [5:0] post_vld;
  int         post_n [6];

  initial begin
    reset_n = 1'b0;
    data_in_data = '0;
    data_in_valid = '0;
    config_in_data = '0;
    config_in_valid = 1'b0;
    trigger_in = 1'b0;

    // Scenario 0: all data delays 0, trigger field 9, one trigger pulse.
    sc[0] = '{cfg: mkcfg(0, 0, 0, 0, 9), chg_edge: -1, cfg2: '0, ch2_vld: '1, trig_edge: 2};
    // Scenario 1: ch0 delay 5, ch3 delay 15.
    sc[1] = '{cfg: mkcfg(5, 0, 0, 15, 0), chg_edge: -1, cfg2: '0, ch2_vld: '1, trig_edge: -1};
    // Scenario 2: ch1 delay 2 changed to 7 at stream edge 10.
    sc[2] = '{cfg: mkcfg(0, 2, 0, 0, 0), chg_edge: 10, cfg2: mkcfg(0, 7, 0, 0, 0),
              ch2_vld: '1, trig_edge: -1};
    // Scenario 3: ch2 delay 3, valid 1,0,1,1 then 0.
    sc[3] = '{cfg: mkcfg(0, 0, 3, 0, 0), chg_edge: -1, cfg2: '0, ch2_vld: 32'hD, trig_edge: -1};

    tbl.push_back('{0, 0, 0, 1'b1, 0});
    tbl.push_back('{0, 0, 7, 1'b1, 0});
    tbl.push_back('{0, 5, 3, 1'b1, 5});
    tbl.push_back('{0, 17, 6, 1'b1, 17});
    tbl.push_back('{0, 1 + TL, -1, 1'b0, 0});
    tbl.push_back('{0, 2 + TL, -1, 1'b1, 0});
    tbl.push_back('{0, 3 + TL, -1, 1'b0, 0});
    tbl.push_back('{1, 0, 1, 1'b1, 0});
    tbl.push_back('{1, 4, 0, 1'b0, 0});
    tbl.push_back('{1, 5, 0, 1'b1, 0});
    tbl.push_back('{1, 9, 0, 1'b1, 4});
    tbl.push_back('{1, 14, 3, 1'b0, 0});
    tbl.push_back('{1, 15, 3, 1'b1, 0});
    tbl.push_back('{1, 20, 3, 1'b1, 5});
    tbl.push_back('{1, 12, -1, 1'b0, 0});
    tbl.push_back('{2, 9, 1, 1'b1, 7});
    tbl.push_back('{2, 10, 1, 1'b1, 8});
    tbl.push_back('{2, 11, 1, 1'b1, 4});
    tbl.push_back('{2, 12, 1, 1'b1, 5});
    tbl.push_back('{2, 20, 1, 1'b1, 13});
    tbl.push_back('{3, 2, 2, 1'b0, 0});
    tbl.push_back('{3, 3, 2, 1'b1, 0});
    tbl.push_back('{3, 4, 2, 1'b0, 0});
    tbl.push_back('{3, 5, 2, 1'b1, 2});
    tbl.push_back('{3, 6, 2, 1'b1, 3});
    tbl.push_back('{3, 7, 2, 1'b0, 0});

    for (int s = 0; s < 4; s++) begin
      do_reset($sformatf("s%0d", s));
      configure(sc[s].cfg);
      for (int k = 0; k < 24; k++) begin
        for (int i = 0; i < CH; i++) begin
          data_in_data[i]  = word(i, k);
          data_in_valid[i] = (i == 2) ? sc[s].ch2_vld[k] : 1'b1;
        end
        trigger_in = (k == sc[s].trig_edge);
        config_in_valid = (k == sc[s].chg_edge);
        config_in_data  = sc[s].cfg2;
        @(posedge clk); #1;
        check($sformatf("s%0d_k%0d_vld_x", s, k), WORD_W'($isunknown(data_out_valid)), '0);
        foreach (tbl[t]) begin
          if (tbl[t].scen == s && tbl[t].cyc == k) begin
            if (tbl[t].ch < 0) begin
              check($sformatf("s%0d_k%0d_trig", s, k), WORD_W'(trigger_out), WORD_W'(tbl[t].ev));
            end else begin
              check($sformatf("s%0d_k%0d_ch%0d_vld", s, k, tbl[t].ch),
                    WORD_W'(data_out_valid[tbl[t].ch]), WORD_W'(tbl[t].ev));
              if (tbl[t].ev)
                check($sformatf("s%0d_k%0d_ch%0d_data", s, k, tbl[t].ch),
                      data_out_data[tbl[t].ch], word(tbl[t].ch, tbl[t].en));
            end
          end
        end
      end
      trigger_in = 1'b0;
      config_in_valid = 1'b0;
    end

    // Reset pulsed mid-stream with ch0 delay 5.
    do_reset("mid");
    configure(mkcfg(5, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      drive_ramp(k, '1);
      @(posedge clk); #1;
    end
    check("mid_pre_vld", WORD_W'(data_out_valid[0]), WORD_W'(1'b1));
    check("mid_pre_data", data_out_data[0], word(0, 14));
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_async_vld",   WORD_W'(data_out_valid), '0);
    check("mid_async_data",  data_out_data[0], '0);
    check("mid_async_ready", WORD_W'(config_in_ready), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive_ramp(100, '1);
    config_in_data  = mkcfg(5, 0, 0, 0, 0);
    config_in_valid = 1'b1;
    #1;
    check("mid_rel_vld", WORD_W'(data_out_valid), '0);
    // First edge after release: delays back to 0, ready not yet high.
    @(posedge clk); #1;
    check("mid_a_vld",   WORD_W'(data_out_valid[0]), WORD_W'(1'b1));
    check("mid_a_data",  data_out_data[0], word(0, 100));
    check("mid_a_ready", WORD_W'(config_in_ready), WORD_W'(1'b1));
    data_in_valid = '0;
    @(posedge clk); #1;
    config_in_valid = 1'b0;
    // Slots 13..15 held pre-reset valid words and must read back invalid.
    post_vld = 6'b101000;
    post_n   = '{0, 0, 0, 100, 0, 0};
    for (int k = 0; k < 6; k++) begin
      drive_ramp(k, '1);
      @(posedge clk); #1;
      check($sformatf("mid_post_k%0d_vld", k), WORD_W'(data_out_valid[0]), WORD_W'(post_vld[k]));
      if (post_vld[k])
        check($sformatf("mid_post_k%0d_data", k), data_out_data[0], word(0, post_n[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
